// File: rtl/cordic_mac_accumulator.sv
// Dot-product accumulator for the CORDIC multiplier product stream, with a valid/ready result hold.
// Define CORDIC_ACC_SAT_EN to saturate on overflow. Without it the accumulator wraps.
module cordic_mac_accumulator #(
  parameter int VEC_LEN   = 8,
  parameter int ACC_WIDTH = 24,
  parameter int CNT_W     = $clog2(VEC_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [15:0]          in_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 overflow,
  output logic                 dropped,
  output logic [CNT_W-1:0]     count
);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 drop_q, drop_d;

  logic [ACC_WIDTH:0]   y_ext;
  logic [ACC_WIDTH:0]   sum;
  logic                 ovf_now;
  logic [ACC_WIDTH-1:0] acc_next;

  assign y_ext   = {{(ACC_WIDTH + 1 - 16){in_y[15]}}, in_y};
  assign sum     = {acc_q[ACC_WIDTH-1], acc_q} + y_ext;
  assign ovf_now = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];

`ifdef CORDIC_ACC_SAT_EN
  // Bit ACC_WIDTH of the wide sum carries the true sign, selecting the clamp rail.
  always_comb begin
    acc_next = sum[ACC_WIDTH-1:0];
    if (ovf_now) begin
      acc_next = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end
`else
  assign acc_next = sum[ACC_WIDTH-1:0];
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    if (state_q == ACCUM) begin
      if (in_valid) begin
        acc_d = acc_next;
        cnt_d = cnt_q + CNT_W'(1);
        ovf_d = ovf_q | ovf_now;
        if (cnt_q == CNT_W'(VEC_LEN - 1)) state_d = HOLD;
      end
    end else begin
      if (out_ready) begin
        // A product in the handoff cycle starts the next vector rather than being dropped.
        state_d = ACCUM;
        ovf_d   = 1'b0;
        if (in_valid) begin
          acc_d = y_ext[ACC_WIDTH-1:0];
          cnt_d = CNT_W'(1);
        end else begin
          acc_d = '0;
          cnt_d = '0;
        end
      end else if (in_valid) begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign acc_out   = acc_q;
  assign overflow  = ovf_q;
  assign dropped   = drop_q;
  assign count     = cnt_q;

endmodule

// File: tb/tb_cordic_mac_accumulator.sv
// Directed bench for cordic_mac_accumulator: default instance plus an ACC_WIDTH=18 overflow instance.
module tb_cordic_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst_n, clear, out_ready;
  logic        in_valid, in_valid2;
  logic [15:0] in_y, in_y2;

  logic        out_valid, overflow, dropped;
  logic [23:0] acc_out;
  logic [3:0]  count;

  logic        out_valid2, overflow2, dropped2;
  logic [17:0] acc_out2;
  logic [3:0]  count2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cordic_mac_accumulator dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_y(in_y),
    .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
    .overflow(overflow), .dropped(dropped), .count(count)
  );

  cordic_mac_accumulator #(.VEC_LEN(8), .ACC_WIDTH(18)) dut18 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid2), .in_y(in_y2),
    .out_valid(out_valid2), .out_ready(out_ready), .acc_out(acc_out2),
    .overflow(overflow2), .dropped(dropped2), .count(count2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic feed(input int n, input logic [15:0] y);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_y     = y;
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_y = '0; in_valid2 = 1'b0; in_y2 = '0;
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_acc",       32'(acc_out),   32'd0);
    chk("rst_overflow",  32'(overflow),  32'd0);
    chk("rst_dropped",   32'(dropped),   32'd0);
    chk("rst_count",     32'(count),     32'd0);
    rst_n = 1'b1;

    // 8 x 0x0100 with out_ready high
    feed(7, 16'h0100);
    chk("v1_count7",     32'(count),     32'd7);
    chk("v1_noval7",     32'(out_valid), 32'd0);
    feed(1, 16'h0100);
    chk("v1_valid",      32'(out_valid), 32'd1);
    chk("v1_acc",        32'(acc_out),   32'h000800);
    chk("v1_ovf",        32'(overflow),  32'd0);
    chk("v1_count8",     32'(count),     32'd8);
    tick();
    chk("v1_valid_drop", 32'(out_valid), 32'd0);
    chk("v1_count_clr",  32'(count),     32'd0);
    chk("v1_acc_clr",    32'(acc_out),   32'd0);

    // Mixed signs
    feed(4, 16'h7FFF);
    feed(4, 16'h8000);
    chk("v2_valid",      32'(out_valid), 32'd1);
    chk("v2_acc",        32'(acc_out),   32'hFFFFFC);
    chk("v2_ovf",        32'(overflow),  32'd0);
    tick();

    // ACC_WIDTH=18 overflow instance
    for (int i = 0; i < 8; i++) begin
      in_valid2 = 1'b1;
      in_y2     = 16'h7FFF;
      tick();
    end
    in_valid2 = 1'b0;
    chk("w18_valid",     32'(out_valid2), 32'd1);
`ifdef CORDIC_ACC_SAT_EN
    chk("w18_acc",       32'(acc_out2),   32'h1FFFF);
`else
    chk("w18_acc",       32'(acc_out2),   32'h3FFF8);
`endif
    chk("w18_ovf",       32'(overflow2),  32'd1);
    tick();
    chk("w18_ovf_clr",   32'(overflow2),  32'd0);
    chk("w18_valid_clr", 32'(out_valid2), 32'd0);

    // Backpressure with dropped products
    out_ready = 1'b0;
    feed(8, 16'h0001);
    chk("bp_valid",      32'(out_valid), 32'd1);
    chk("bp_acc0",       32'(acc_out),   32'd8);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      in_y     = 16'h0001;
      tick();
    end
    in_valid = 1'b0;
    chk("bp_acc_stable", 32'(acc_out),   32'd8);
    chk("bp_count",      32'(count),     32'd8);
    chk("bp_still_val",  32'(out_valid), 32'd1);
    chk("bp_dropped",    32'(dropped),   32'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_handoff",    32'(out_valid), 32'd0);
    chk("bp_count0",     32'(count),     32'd0);
    chk("bp_drop_stick", 32'(dropped),   32'd1);

    // Handoff collision
    out_ready = 1'b0;
    feed(8, 16'h0001);
    chk("col_valid",     32'(out_valid), 32'd1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_y      = 16'h0010;
    tick();
    in_valid = 1'b0;
    chk("col_valid0",    32'(out_valid), 32'd0);
    chk("col_count1",    32'(count),     32'd1);
    chk("col_acc16",     32'(acc_out),   32'd16);

    // Clear discards everything including dropped
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_acc",       32'(acc_out),   32'd0);
    chk("clr_count",     32'(count),     32'd0);
    chk("clr_dropped",   32'(dropped),   32'd0);

    // Reset mid-vector
    feed(3, 16'h0100);
    chk("mid_acc",       32'(acc_out),   32'h000300);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_acc",   32'(acc_out),   32'd0);
    chk("mid_rst_count", 32'(count),     32'd0);
    chk("mid_rst_val",   32'(out_valid), 32'd0);
    chk("mid_rst_ovf",   32'(overflow),  32'd0);
    chk("mid_rst_drop",  32'(dropped),   32'd0);
    feed(8, 16'h0001);
    chk("post_rst_val",  32'(out_valid), 32'd1);
    chk("post_rst_acc",  32'(acc_out),   32'd8);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
